// File: rtl/multiplier_datapath_taint_track_word.sv
// Shift-add datapath for a sequential multiplier: multiplicand, multiplier and
// running-sum registers, each carrying a sticky word-level taint bit.
module multiplier_datapath_taint_track_word #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               multiplicand_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               multiplier_t,
  input  logic               rsload,
  input  logic               rsload_t,
  input  logic               rsclear,
  input  logic               rsclear_t,
  input  logic               rsshr,
  input  logic               rsshr_t,
  input  logic               mrld,
  input  logic               mrld_t,
  input  logic               mdld,
  input  logic               mdld_t,
  output logic [WIDTH-1:0]   multiplierReg,
  output logic               multiplierReg_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t
);

  logic [WIDTH-1:0] md;
  logic             md_t;
  logic [WIDTH-1:0] mr;
  logic             mr_t;
  logic [2*WIDTH:0] rs;
  logic             rs_t;

  // Upper part of the running sum plus multiplicand; the extra bit is the
  // guard that absorbs the carry before the next shift.
  logic [WIDTH:0]   upper_sum;

  always_comb begin
    upper_sum = rs[2*WIDTH:WIDTH] + {1'b0, md};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      md   <= '0;
      md_t <= 1'b0;
      mr   <= '0;
      mr_t <= 1'b0;
    end else begin
      if (mdld) md <= multiplicand;
      md_t <= (mdld ? multiplicand_t : md_t) | mdld_t;
      if (mrld) mr <= multiplier;
      mr_t <= (mrld ? multiplier_t : mr_t) | mrld_t;
    end
  end

  // Strobe priority: clear, then load, then shift. The add reads the current
  // md/md_t, so a same-cycle mdld only affects later additions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rs   <= '0;
      rs_t <= 1'b0;
    end else if (rsclear) begin
      rs   <= '0;
      rs_t <= rsclear_t;
    end else begin
      if (rsload) begin
        rs[2*WIDTH:WIDTH] <= upper_sum;
      end else if (rsshr) begin
        rs <= {1'b0, rs[2*WIDTH:1]};
      end
      rs_t <= rs_t | rsclear_t | rsload_t | rsshr_t | (rsload & md_t);
    end
  end

  assign multiplierReg   = mr;
  assign multiplierReg_t = mr_t;
  assign product         = rs[2*WIDTH-1:0];
  assign product_t       = rs_t;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// Directed bench for the shift-add datapath: drives the control sequence from
// the bench and checks product, multiplier register and taints.
module tb_multiplier_datapath_taint_track_word;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   multiplicand;
  logic               multiplicand_t;
  logic [WIDTH-1:0]   multiplier;
  logic               multiplier_t;
  logic               rsload, rsload_t;
  logic               rsclear, rsclear_t;
  logic               rsshr, rsshr_t;
  logic               mrld, mrld_t;
  logic               mdld, mdld_t;
  logic [WIDTH-1:0]   multiplierReg;
  logic               multiplierReg_t;
  logic [2*WIDTH-1:0] product;
  logic               product_t;

  int checks = 0;
  int errors = 0;

  multiplier_datapath_taint_track_word #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .multiplicand   (multiplicand),
    .multiplicand_t (multiplicand_t),
    .multiplier     (multiplier),
    .multiplier_t   (multiplier_t),
    .rsload         (rsload),
    .rsload_t       (rsload_t),
    .rsclear        (rsclear),
    .rsclear_t      (rsclear_t),
    .rsshr          (rsshr),
    .rsshr_t        (rsshr_t),
    .mrld           (mrld),
    .mrld_t         (mrld_t),
    .mdld           (mdld),
    .mdld_t         (mdld_t),
    .multiplierReg  (multiplierReg),
    .multiplierReg_t(multiplierReg_t),
    .product        (product),
    .product_t      (product_t)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    multiplicand = '0; multiplicand_t = 1'b0;
    multiplier = '0;   multiplier_t = 1'b0;
    rsload = 1'b0;  rsload_t = 1'b0;
    rsclear = 1'b0; rsclear_t = 1'b0;
    rsshr = 1'b0;   rsshr_t = 1'b0;
    mrld = 1'b0;    mrld_t = 1'b0;
    mdld = 1'b0;    mdld_t = 1'b0;
  endtask

  // Apply the current inputs for one edge, then return the strobes to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_init(input logic [WIDTH-1:0] a, input logic a_t,
                         input logic [WIDTH-1:0] b, input logic b_t);
    multiplicand = a; multiplicand_t = a_t; mdld = 1'b1;
    multiplier = b;   multiplier_t = b_t;   mrld = 1'b1;
    rsclear = 1'b1;
    tick();
  endtask

  task automatic do_iter(input logic bit_i);
    rsshr = 1'b1;
    tick();
    rsload = bit_i;
    tick();
  endtask

  task automatic do_final();
    rsshr = 1'b1;
    tick();
  endtask

  task automatic do_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    do_init(a, 1'b0, b, 1'b0);
    for (int i = 0; i < WIDTH; i++) do_iter(b[i]);
    do_final();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    multiplicand = 4'hF; multiplicand_t = 1'b1; mdld = 1'b1; mdld_t = 1'b1;
    multiplier = 4'hF;   multiplier_t = 1'b1;   mrld = 1'b1; mrld_t = 1'b1;
    rsload = 1'b1; rsload_t = 1'b1;
    rsclear = 1'b1; rsclear_t = 1'b1;
    rsshr = 1'b1; rsshr_t = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (product !== 8'h00 || multiplierReg !== 4'h0 || product_t !== 1'b0 ||
        multiplierReg_t !== 1'b0 || dut.md_t !== 1'b0) begin
      errors++;
      $display("FAIL reset: product=%h mr=%h product_t=%b mr_t=%b md_t=%b required 00 0 0 0 0",
               product, multiplierReg, product_t, multiplierReg_t, dut.md_t);
    end
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_13x11();
    do_init(4'd13, 1'b0, 4'd11, 1'b0);
    checks++;
    if (multiplierReg !== 4'd11 || product !== 8'd0) begin
      errors++;
      $display("FAIL init_13x11: mr=%0d product=%0d required 11 0", multiplierReg, product);
    end
    do_iter(1'b1);
    checks++;
    if (product !== 8'hD0) begin
      errors++;
      $display("FAIL iter0_13x11: product=%h required d0", product);
    end
    do_iter(1'b1); do_iter(1'b0); do_iter(1'b1);
    do_final();
    checks++;
    if (product !== 8'd143 || product_t !== 1'b0) begin
      errors++;
      $display("FAIL mult_13x11: product=%0d product_t=%b required 143 0", product, product_t);
    end
  endtask

  task automatic test_mult_edges();
    do_mult(4'd15, 4'd15);
    checks++;
    if (product !== 8'd225) begin
      errors++;
      $display("FAIL mult_15x15: product=%0d required 225", product);
    end
    do_mult(4'd0, 4'd9);
    checks++;
    if (product !== 8'd0) begin
      errors++;
      $display("FAIL mult_0x9: product=%0d required 0", product);
    end
    do_mult(4'd9, 4'd0);
    checks++;
    if (product !== 8'd0) begin
      errors++;
      $display("FAIL mult_9x0: product=%0d required 0", product);
    end
  endtask

  task automatic test_md_taint();
    do_init(4'd5, 1'b1, 4'd4, 1'b0);
    checks++;
    if (dut.md_t !== 1'b1 || product_t !== 1'b0 || multiplierReg_t !== 1'b0) begin
      errors++;
      $display("FAIL md_taint_init: md_t=%b product_t=%b mr_t=%b required 1 0 0",
               dut.md_t, product_t, multiplierReg_t);
    end
    do_iter(1'b0); do_iter(1'b0);
    rsshr = 1'b1;
    tick();
    checks++;
    if (product_t !== 1'b0) begin
      errors++;
      $display("FAIL md_taint_pre_load: product_t=%b required 0", product_t);
    end
    rsload = 1'b1;
    tick();
    checks++;
    if (product_t !== 1'b1) begin
      errors++;
      $display("FAIL md_taint_load: product_t=%b required 1", product_t);
    end
    do_iter(1'b0);
    do_final();
    checks++;
    if (product !== 8'd20 || product_t !== 1'b1) begin
      errors++;
      $display("FAIL md_taint_5x4: product=%0d product_t=%b required 20 1", product, product_t);
    end
    do_init(4'd5, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < WIDTH; i++) do_iter(1'b0);
    do_final();
    checks++;
    if (product_t !== 1'b0 || product !== 8'd0) begin
      errors++;
      $display("FAIL md_taint_mr0: product=%0d product_t=%b required 0 0", product, product_t);
    end
  endtask

  task automatic test_strobe_taint();
    rsload_t = 1'b1;
    tick();
    checks++;
    if (product_t !== 1'b1) begin
      errors++;
      $display("FAIL strobe_taint_set: product_t=%b required 1", product_t);
    end
    tick(); tick();
    checks++;
    if (product_t !== 1'b1) begin
      errors++;
      $display("FAIL strobe_taint_sticky: product_t=%b required 1", product_t);
    end
    rsclear = 1'b1;
    tick();
    checks++;
    if (product_t !== 1'b0) begin
      errors++;
      $display("FAIL strobe_taint_clear: product_t=%b required 0", product_t);
    end
  endtask

  task automatic test_reset_mid();
    do_init(4'd11, 1'b1, 4'd7, 1'b1);
    do_iter(1'b1); do_iter(1'b1); do_iter(1'b1);
    rsshr_t = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (product !== 8'd0 || multiplierReg !== 4'd0 || product_t !== 1'b0 ||
        multiplierReg_t !== 1'b0 || dut.md_t !== 1'b0 || dut.md !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: product=%0d mr=%0d product_t=%b mr_t=%b md=%0d md_t=%b required all 0",
               product, multiplierReg, product_t, multiplierReg_t, dut.md, dut.md_t);
    end
    do_mult(4'd7, 4'd6);
    checks++;
    if (product !== 8'd42 || product_t !== 1'b0) begin
      errors++;
      $display("FAIL restart_7x6: product=%0d product_t=%b required 42 0", product, product_t);
    end
    rsclear = 1'b1; rsload = 1'b1; rsload_t = 1'b1;
    tick();
    checks++;
    if (product !== 8'd0 || product_t !== 1'b0 || dut.rs !== 9'd0) begin
      errors++;
      $display("FAIL clear_load: product=%0d rs=%0d product_t=%b required 0 0 0",
               product, dut.rs, product_t);
    end
  endtask

  // Priority of load over shift, and add using the pre-load multiplicand.
  task automatic test_back_to_back();
    do_init(4'd3, 1'b0, 4'd1, 1'b0);
    rsload = 1'b1; rsshr = 1'b1;
    tick();
    checks++;
    if (product !== 8'h30) begin
      errors++;
      $display("FAIL load_over_shift: product=%h required 30", product);
    end
    multiplicand = 4'd9; multiplicand_t = 1'b1; mdld = 1'b1; rsload = 1'b1;
    tick();
    checks++;
    if (product !== 8'h60 || product_t !== 1'b0 || dut.md !== 4'd9) begin
      errors++;
      $display("FAIL mdld_with_load: product=%h product_t=%b md=%0d required 60 0 9",
               product, product_t, dut.md);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_mult_13x11();
    test_mult_edges();
    test_md_taint();
    test_strobe_taint();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
